// File: rtl/iic_burst_ctrl.sv
// IIC transaction sequencer: expands one write/read request into the
// byte/condition command stream for iic_tim_gen, with NACK abort and delay.
module iic_burst_ctrl #(
  parameter int ADDR_BYTES_MAX = 2,
  parameter int DATA_BYTES_MAX = 4,
  parameter int DLY_W          = 32
) (
  input  logic                        i_sysclk,
  input  logic                        i_sysrst_n,
  input  logic                        wr_req,
  input  logic                        rd_req,
  input  logic [7:0]                  device_id,
  input  logic [8*ADDR_BYTES_MAX-1:0] addr,
  input  logic [2:0]                  addr_len,
  input  logic [4:0]                  data_len,
  input  logic [8*DATA_BYTES_MAX-1:0] wr_data,
  input  logic [DLY_W-1:0]            dly_cnt_max,
  output logic [8*DATA_BYTES_MAX-1:0] rd_data,
  output logic                        busy,
  output logic                        rw_done,
  output logic                        ack_err,
  output logic [5:0]                  eng_cmd,
  output logic [7:0]                  eng_tx_data,
  output logic                        eng_go,
  input  logic                        eng_done,
  input  logic                        eng_ack,
  input  logic [7:0]                  eng_rx_data
);

  localparam logic [5:0] C_WR   = 6'h01;
  localparam logic [5:0] C_STA  = 6'h02;
  localparam logic [5:0] C_RD   = 6'h04;
  localparam logic [5:0] C_STO  = 6'h08;
  localparam logic [5:0] C_ACK  = 6'h10;
  localparam logic [5:0] C_NACK = 6'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ABORT,
    S_ABORT_WAIT,
    S_DELAY,
    S_DONE
  } state_t;

  // Which part of the byte stream the current byte belongs to.
  typedef enum logic [1:0] {
    P_ID,
    P_ADDR,
    P_RID,
    P_DATA
  } phase_t;

  state_t state, state_n, fin;
  phase_t phase, adv_phase;

  logic [4:0]                  idx, adv_idx;
  logic                        is_rd;
  logic [7:0]                  dev_q;
  logic [8*ADDR_BYTES_MAX-1:0] addr_q;
  logic [2:0]                  alen_q, alen_c;
  logic [4:0]                  dlen_q, dlen_c;
  logic [8*DATA_BYTES_MAX-1:0] wdata_q;
  logic [DLY_W-1:0]            dly_q, cnt;

  logic       accept, step, wr_dir, last_byte, nack;
  logic [7:0] abyte, wbyte;
  logic [5:0] issue_cmd;
  logic [7:0] issue_tx;

  assign accept = (state == S_IDLE) && (wr_req || rd_req);
  assign step   = (state == S_WAIT) && eng_done;

  always_comb begin
    alen_c = addr_len;
    if (addr_len > 3'(ADDR_BYTES_MAX)) alen_c = 3'(ADDR_BYTES_MAX);
    dlen_c = data_len;
    if (data_len == 5'd0) dlen_c = 5'd1;
    else if (data_len > 5'(DATA_BYTES_MAX)) dlen_c = 5'(DATA_BYTES_MAX);
  end

  assign wr_dir    = (phase != P_DATA) || !is_rd;
  assign last_byte = (phase == P_DATA) && (idx == dlen_q - 5'd1);
  assign nack      = wr_dir && eng_ack;
  assign fin       = (dly_q == '0) ? S_DONE : S_DELAY;

  always_comb begin
    abyte = '0;
    for (int i = 0; i < ADDR_BYTES_MAX; i++)
      if (idx == 5'(i)) abyte = addr_q[8*i +: 8];
  end

  always_comb begin
    wbyte = '0;
    for (int i = 0; i < DATA_BYTES_MAX; i++)
      if (idx == 5'(i)) wbyte = wdata_q[8*i +: 8];
  end

  always_comb begin
    issue_cmd = '0;
    issue_tx  = '0;
    unique case (phase)
      P_ID: begin
        issue_cmd = C_STA | C_WR;
        issue_tx  = dev_q & 8'hFE;
      end
      P_ADDR: begin
        issue_cmd = C_WR;
        issue_tx  = abyte;
      end
      P_RID: begin
        issue_cmd = C_STA | C_WR;
        issue_tx  = dev_q | 8'h01;
      end
      P_DATA: begin
        if (is_rd) begin
          issue_cmd = last_byte ? (C_RD | C_NACK | C_STO)
                                : (C_RD | C_ACK);
        end else begin
          issue_cmd = last_byte ? (C_WR | C_STO) : C_WR;
          issue_tx  = wbyte;
        end
      end
      default: ;
    endcase
  end

  // Address bytes go out MSB first, so idx counts down in P_ADDR.
  always_comb begin
    adv_phase = phase;
    adv_idx   = idx + 5'd1;
    unique case (phase)
      P_ID: begin
        if (alen_q != 3'd0) begin
          adv_phase = P_ADDR;
          adv_idx   = 5'(alen_q) - 5'd1;
        end else begin
          adv_phase = P_DATA;
          adv_idx   = '0;
        end
      end
      P_ADDR: begin
        if (idx != 5'd0) begin
          adv_idx = idx - 5'd1;
        end else begin
          adv_phase = is_rd ? P_RID : P_DATA;
          adv_idx   = '0;
        end
      end
      P_RID: begin
        adv_phase = P_DATA;
        adv_idx   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) state <= S_IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          if (last_byte)  state_n = fin;
          else if (nack)  state_n = S_ABORT;
          else            state_n = S_ISSUE;
        end
      end
      S_ABORT:      state_n = S_ABORT_WAIT;
      S_ABORT_WAIT: if (eng_done) state_n = fin;
      S_DELAY:      if (cnt == dly_q) state_n = S_DONE;
      S_DONE:       state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      phase   <= P_ID;
      idx     <= '0;
      is_rd   <= 1'b0;
      dev_q   <= '0;
      addr_q  <= '0;
      alen_q  <= '0;
      dlen_q  <= 5'd1;
      wdata_q <= '0;
      dly_q   <= '0;
      cnt     <= '0;
      ack_err <= 1'b0;
      rd_data <= '0;
    end else begin
      if (accept) begin
        is_rd   <= !wr_req;
        dev_q   <= device_id;
        addr_q  <= addr;
        alen_q  <= alen_c;
        dlen_q  <= dlen_c;
        wdata_q <= wr_data;
        dly_q   <= dly_cnt_max;
        ack_err <= 1'b0;
        idx     <= '0;
        phase   <= (!wr_req && alen_c == 3'd0) ? P_RID : P_ID;
      end
      if (step) begin
        if (nack) ack_err <= 1'b1;
        if (state_n == S_ISSUE) begin
          phase <= adv_phase;
          idx   <= adv_idx;
        end
        for (int i = 0; i < DATA_BYTES_MAX; i++)
          if (is_rd && phase == P_DATA && idx == 5'(i))
            rd_data[8*i +: 8] <= eng_rx_data;
      end
      if (state_n == S_DELAY && state != S_DELAY)
        cnt <= DLY_W'(1);
      else if (state == S_DELAY)
        cnt <= cnt + DLY_W'(1);
    end
  end

  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign rw_done = (state == S_DONE);
  assign eng_go  = (state == S_ISSUE) || (state == S_ABORT);

  always_comb begin
    eng_cmd     = '0;
    eng_tx_data = '0;
    if (state == S_ISSUE) begin
      eng_cmd     = issue_cmd;
      eng_tx_data = issue_tx;
    end else if (state == S_ABORT) begin
      eng_cmd = C_STO;
    end
  end

endmodule

// File: tb/tb_iic_burst_ctrl.sv
// Bench for iic_burst_ctrl: behavioural engine plus a list-based
// reference of the expected IIC command stream per request.
module tb_iic_burst_ctrl;
  localparam int AM = 2;
  localparam int DM = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req, rd_req;
  logic [7:0]    device_id;
  logic [8*AM-1:0] addr;
  logic [2:0]    addr_len;
  logic [4:0]    data_len;
  logic [8*DM-1:0] wr_data;
  logic [DW-1:0] dly_cnt_max;
  logic [8*DM-1:0] rd_data;
  logic          busy, rw_done, ack_err;
  logic [5:0]    eng_cmd;
  logic [7:0]    eng_tx_data;
  logic          eng_go;
  logic          eng_done, eng_ack;
  logic [7:0]    eng_rx_data;

  always #5 clk = ~clk;

  iic_burst_ctrl #(
    .ADDR_BYTES_MAX(AM),
    .DATA_BYTES_MAX(DM),
    .DLY_W(DW)
  ) dut (
    .i_sysclk(clk),
    .i_sysrst_n(rst_n),
    .wr_req(wr_req),
    .rd_req(rd_req),
    .device_id(device_id),
    .addr(addr),
    .addr_len(addr_len),
    .data_len(data_len),
    .wr_data(wr_data),
    .dly_cnt_max(dly_cnt_max),
    .rd_data(rd_data),
    .busy(busy),
    .rw_done(rw_done),
    .ack_err(ack_err),
    .eng_cmd(eng_cmd),
    .eng_tx_data(eng_tx_data),
    .eng_go(eng_go),
    .eng_done(eng_done),
    .eng_ack(eng_ack),
    .eng_rx_data(eng_rx_data)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int go_cnt = 0;
  int rwd_cnt = 0;
  int done_cyc = 0;
  int nack_idx = -1;
  int rk = 0;
  logic [5:0] cap_cmd[$];
  logic [7:0] cap_tx[$];
  logic [7:0] rxb[16];
  logic [31:0] exp_rd = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_go) go_cnt <= go_cnt + 1;
    if (rw_done) rwd_cnt <= rwd_cnt + 1;
  end

  // Engine: one done pulse 1..4 cycles after each go.
  initial begin
    eng_done = 1'b0;
    eng_ack = 1'b0;
    eng_rx_data = '0;
    forever begin
      @(posedge clk); #1;
      while (eng_go) begin
        automatic int ci = cap_cmd.size();
        automatic logic [5:0] c = eng_cmd;
        cap_cmd.push_back(eng_cmd);
        cap_tx.push_back(eng_tx_data);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        eng_done = 1'b1;
        eng_ack = (ci == nack_idx);
        eng_rx_data = 8'($urandom);
        if (c[2]) begin
          eng_rx_data = rxb[rk];
          rk++;
        end
        done_cyc = cyc;
        @(posedge clk); #1;
        eng_done = 1'b0;
        eng_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic txn(input bit rd, input logic [7:0] dev,
                     input logic [15:0] a, input logic [2:0] al,
                     input logic [4:0] dl, input logic [31:0] wd,
                     input logic [31:0] dly, input int nk,
                     input bit intrude);
    logic [5:0] ec[$];
    logic [7:0] et[$];
    int ea, ed, n, g0, r0, rc;
    bit eerr;
    ea = (al > AM) ? AM : int'(al);
    ed = (dl == 0) ? 1 : ((dl > DM) ? DM : int'(dl));
    if (!rd || ea > 0) begin
      ec.push_back(6'h03); et.push_back(dev & 8'hFE);
    end
    for (int j = ea - 1; j >= 0; j--) begin
      ec.push_back(6'h01); et.push_back(a[8*j +: 8]);
    end
    if (rd) begin
      ec.push_back(6'h03); et.push_back(dev | 8'h01);
    end
    for (int k = 0; k < ed; k++) begin
      if (rd) begin
        ec.push_back(k == ed - 1 ? 6'h2C : 6'h14); et.push_back(8'h00);
      end else begin
        ec.push_back(k == ed - 1 ? 6'h09 : 6'h01); et.push_back(wd[8*k +: 8]);
      end
    end
    eerr = 1'b0;
    n = ec.size();
    for (int i = 0; i < n; i++) begin
      if (!ec[i][2] && i == nk) begin
        eerr = 1'b1;
        if (i != n - 1) begin
          while (ec.size() > i + 1) begin
            void'(ec.pop_back()); void'(et.pop_back());
          end
          ec.push_back(6'h08); et.push_back(8'h00);
        end
        break;
      end
    end
    rc = 0;
    foreach (ec[i]) if (ec[i][2]) begin
      exp_rd[8*rc +: 8] = rxb[rc];
      rc++;
    end

    nack_idx = nk;
    rk = 0;
    cap_cmd.delete();
    cap_tx.delete();
    g0 = go_cnt;
    r0 = rwd_cnt;
    @(negedge clk);
    device_id = dev; addr = a; addr_len = al; data_len = dl;
    wr_data = wd; dly_cnt_max = dly;
    wr_req = !rd;
    rd_req = rd ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    chk("busy_rise", busy, 1);
    device_id = 8'($urandom); addr = 16'($urandom);
    wr_data = $urandom; addr_len = 3'($urandom);
    data_len = 5'($urandom); dly_cnt_max = 32'($urandom_range(0, 9));
    if (intrude) begin
      wr_req = 1'b1; rd_req = 1'b1;
    end
    n = 0;
    while (!rw_done && n < 600) begin
      @(negedge clk); n++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("rw_done_seen", rw_done, 1);
    chk("busy_in_done", busy, 0);
    chk("ack_err", ack_err, eerr);
    chk("done_latency", 64'(cyc - done_cyc), 64'(dly) + 1);
    chk("n_cmds", cap_cmd.size(), ec.size());
    for (int i = 0; i < ec.size() && i < cap_cmd.size(); i++) begin
      chk($sformatf("cmd%0d", i), cap_cmd[i], ec[i]);
      if (ec[i][0]) chk($sformatf("tx%0d", i), cap_tx[i], et[i]);
    end
    chk("rd_data", rd_data, exp_rd);
    @(negedge clk);
    chk("done_1cyc", rw_done, 0);
    repeat (3) @(negedge clk);
    chk("go_pulses", go_cnt - g0, ec.size());
    chk("done_pulses", rwd_cnt - r0, 1);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int n;
    wr_req = 0; rd_req = 0; device_id = 0; addr = 0; addr_len = 0;
    data_len = 0; wr_data = 0; dly_cnt_max = 0;
    foreach (rxb[i]) rxb[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", rw_done, 0);
    chk("rst_go", eng_go, 0);
    chk("rst_cmd", eng_cmd, 0);
    chk("rst_tx", eng_tx_data, 0);
    chk("rst_err", ack_err, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1'b1;

    txn(0, 8'h78, 16'h3008, 3'd2, 5'd1, 32'h82, 0, -1, 0);
    rxb[0] = 8'h56; rxb[1] = 8'h40;
    txn(1, 8'h78, 16'h300A, 3'd2, 5'd2, 0, 0, -1, 0);
    chk("rd16", rd_data[15:0], 16'h4056);
    txn(0, 8'h78, 16'h3008, 3'd2, 5'd2, 32'hBEEF, 2, 1, 0);
    txn(0, 8'h78, 16'h1234, 3'd2, 5'd3, 32'h00AABBCC, 5, -1, 1);
    foreach (rxb[i]) rxb[i] = 8'($urandom);
    txn(1, 8'h78, 16'h0000, 3'd0, 5'd20, 0, 1, -1, 0);
    txn(0, 8'h42, 16'h5566, 3'd7, 5'd4, 32'h01020304, 0, 5, 0);

    nack_idx = -1;
    rk = 0;
    cap_cmd.delete();
    cap_tx.delete();
    @(negedge clk);
    device_id = 8'h78; addr = 16'h3008; addr_len = 2; data_len = 4;
    wr_data = 32'h11223344; dly_cnt_max = 0; wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    n = 0;
    while (cap_cmd.size() < 2 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("rst_mid_reach", cap_cmd.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_go", eng_go, 0);
    chk("arst_cmd", eng_cmd, 0);
    chk("arst_err", ack_err, 0);
    chk("arst_rd", rd_data, 0);
    exp_rd = '0;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    txn(0, 8'h78, 16'h3008, 3'd2, 5'd1, 32'h82, 0, -1, 0);

    for (int it = 0; it < 25; it++) begin
      automatic int nk = ($urandom_range(0, 2) == 0) ?
                         int'($urandom_range(0, 8)) : -1;
      foreach (rxb[i]) rxb[i] = 8'($urandom);
      txn(1'($urandom), 8'($urandom), 16'($urandom), 3'($urandom),
          5'($urandom), $urandom, 32'($urandom_range(0, 6)), nk,
          1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iic_burst_ctrl.md
Name: iic_burst_ctrl

Overview:
Transaction sequencer for the camera-init IIC path. It sits between the register-table walker and the byte-level iic_tim_gen engine. It turns one write/read request into the full IIC byte sequence, with 0..ADDR_BYTES_MAX register-address bytes and 1..DATA_BYTES_MAX data bytes per transaction. It adds slave-NACK abort with forced STOP, an error flag and a post-transaction delay.

Parameters:
ADDR_BYTES_MAX, 2, max register-address bytes (1..4)
DATA_BYTES_MAX, 4, max data bytes per burst (1..16)
DLY_W, 32, width of post-transaction delay counter

Ports:
i_sysclk  in  1  system clock
i_sysrst_n  in  1  async active-low reset
wr_req  in  1  write request, sampled in IDLE only
rd_req  in  1  read request, sampled in IDLE only
device_id  in  8  7-bit slave address in [7:1]; bit0 ignored
addr  in  8*ADDR_BYTES_MAX  register address, LSB-aligned
addr_len  in  3  address bytes to send, 0..ADDR_BYTES_MAX
data_len  in  5  data bytes, 1..DATA_BYTES_MAX
wr_data  in  8*DATA_BYTES_MAX  write payload, byte k = [8k+7:8k]
dly_cnt_max  in  DLY_W  idle cycles after STOP before done
rd_data  out  8*DATA_BYTES_MAX  read payload, byte k = [8k+7:8k]
busy  out  1  transaction in progress
rw_done  out  1  one-cycle completion pulse
ack_err  out  1  slave NACKed a write-direction byte in the last transaction
eng_cmd  out  6  engine command: WR=01h STA=02h RD=04h STO=08h ACK=10h NACK=20h, OR-able
eng_tx_data  out  8  byte to the engine
eng_go  out  1  one-cycle engine start pulse
eng_done  in  1  engine byte/condition complete pulse
eng_ack  in  1  1 = slave NACK sampled on the last written byte
eng_rx_data  in  8  byte received by the engine

Behaviour:
- Reset: all outputs 0, FSM to IDLE. Reset mid-transaction aborts immediately with no STOP issued; the engine is reset by the same i_sysrst_n.
- Request acceptance:
  - In IDLE, wr_req has priority over rd_req.
  - On acceptance, latch all inputs into a shadow copy. Input changes during busy are ignored.
  - busy rises the cycle after acceptance and falls in the rw_done cycle.
  - Requests asserted while busy are dropped.
- Length clamping: addr_len > ADDR_BYTES_MAX is treated as ADDR_BYTES_MAX. data_len = 0 is treated as 1; data_len > DATA_BYTES_MAX is treated as DATA_BYTES_MAX.
- States: IDLE, ISSUE, WAIT, ABORT, ABORT_WAIT, DELAY, DONE.
  - ISSUE drives eng_cmd/eng_tx_data and pulses eng_go for exactly 1 cycle, then goes to WAIT.
  - WAIT holds until eng_done, then moves to the next byte's ISSUE, to ABORT, or to DELAY.
- Write sequence:
  - STA|WR, {device_id[7:1],0}.
  - Address bytes, MSB first: addr[8*addr_len-1 -: 8] down to addr[7:0], each WR.
  - Data bytes 0..n-1, each WR; the last is WR|STO.
- Read sequence:
  - If addr_len > 0: STA|WR with ID, then address bytes (WR, no STO), then STA|WR with {device_id[7:1],1}.
  - If addr_len = 0: send only STA|WR with ID|1 (current-address read).
  - Data bytes: RD|ACK for all but the last; the last is RD|NACK|STO.
  - On each read byte's eng_done, write eng_rx_data into rd_data byte k. Bytes ≥ data_len keep their previous value.
- NACK handling:
  - eng_ack is checked on every write-direction byte (ID, address, write data) at eng_done.
  - On the first eng_ack = 1: set ack_err and go to ABORT.
  - ABORT issues eng_cmd = STO with one go pulse; ABORT_WAIT waits for eng_done, then goes to DELAY.
  - No further bytes are sent. rd_data bytes not yet received are unchanged.
  - A NACK on the final WR|STO byte sets ack_err but needs no extra STOP.
- ack_err is cleared at acceptance of the next request and held otherwise.
- DELAY: counts exactly dly_cnt_max cycles (0 means none) after the final eng_done, then goes to DONE.
- DONE: rw_done = 1 for one cycle, busy = 0 in the same cycle, then back to IDLE.
- A new request may be accepted the cycle after DONE.
- eng_go is never asserted while waiting for eng_done. eng_done outside WAIT/ABORT_WAIT is ignored.

Test Plan:
- Write, addr_len=2, addr=3008h, data_len=1, wr_data=82h, dly=0, ACKs → engine sees STA|WR 78h, WR 30h, WR 08h, WR|STO 82h; rw_done pulses once; ack_err=0.
- Read, addr_len=2, addr=300Ah, data_len=2, device_id 78h, rx 56h then 40h → cmds STA|WR 78h, WR 30h, WR 0Ah, STA|WR 79h, RD|ACK, RD|NACK|STO; rd_data[15:0]=4056h.
- Write where eng_ack=1 on the second byte (addr MSB) → ack_err=1; next command is STO alone; no data bytes sent; rw_done pulses after STO done.
- dly_cnt_max=5 after a write → rw_done exactly 5 cycles after the final eng_done; a new wr_req during busy is ignored (no extra transaction).
- Read addr_len=0, data_len=20 with DATA_BYTES_MAX=4 → clamped to 4 bytes; first command STA|WR 79h; bytes 0-2 RD|ACK, byte 3 RD|NACK|STO.
- Assert i_sysrst_n low mid-address byte → all outputs 0 next edge; FSM IDLE; a fresh wr_req after release completes normally.
